// File: rtl/slc_config_sequencer.sv
// rtl/slc_config_sequencer.sv - loads, serialises and commits one super logic cell's config image
// Config words fill a shadow image; commit drains QEN, shifts the image MSB first, then latches once.
module slc_config_sequencer #(
  parameter int NUM_LC    = 8,
  parameter int SHIFT_DIV = 2,
  parameter int DRAIN_CYC = 2,
  localparam int IW = (NUM_LC > 1) ? $clog2(NUM_LC) : 1
) (
  input  logic          QCK,
  input  logic          QRTN,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [IW-1:0] cfg_idx,
  input  logic [3:0]    cfg_data,
  input  logic          commit,
  input  logic          user_qen,
  output logic          slc_qen,
  output logic          sdata,
  output logic          sclk_en,
  output logic          cfg_latch,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int W  = 4 * NUM_LC;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int RW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [BW-1:0] BIT_LAST   = BW'(W - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SHIFT_DIV - 1);
  localparam logic [RW-1:0] DRAIN_LAST = RW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SHIFT,
    S_LATCH,
    S_RESUME
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  image_q, image_d;
  logic [NUM_LC-1:0] mask_q, mask_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic [RW-1:0] drain_q, drain_d;
  logic          sdata_q, sdata_d;
  logic          sclk_en_q, sclk_en_d;
  logic          cfg_latch_q, cfg_latch_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [W-1:0]      wr_image;
  logic [NUM_LC-1:0] wr_mask;

  always_comb begin
    state_d  = state_q;
    image_d  = image_q;
    mask_d   = mask_q;
    bit_d    = bit_q;
    div_d    = div_q;
    drain_d  = drain_q;
    err_d    = 1'b0;
    wr_image = image_q;
    wr_mask  = mask_q;

    // A write landing in the commit cycle counts toward completeness.
    if (cfg_valid) begin
      wr_image[{cfg_idx, 2'b00} +: 4] = cfg_data;
      wr_mask[cfg_idx]                = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        image_d = wr_image;
        mask_d  = wr_mask;
        if (commit) begin
          if (&wr_mask) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_SHIFT;
          bit_d   = '0;
          div_d   = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_LATCH;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LATCH: state_d = S_RESUME;
      S_RESUME: begin
        state_d = S_IDLE;
        mask_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with the state they describe.
    busy_d      = (state_d != S_IDLE);
    sdata_d     = (state_d == S_SHIFT) ? image_q[BIT_LAST - bit_d] : 1'b0;
    sclk_en_d   = (state_d == S_SHIFT) && (div_d == DIV_LAST);
    cfg_latch_d = (state_d == S_LATCH);
    done_d      = (state_d == S_RESUME);
  end

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state_q     <= S_IDLE;
      image_q     <= '0;
      mask_q      <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      drain_q     <= '0;
      sdata_q     <= 1'b0;
      sclk_en_q   <= 1'b0;
      cfg_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      image_q     <= image_d;
      mask_q      <= mask_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      drain_q     <= drain_d;
      sdata_q     <= sdata_d;
      sclk_en_q   <= sclk_en_d;
      cfg_latch_q <= cfg_latch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cfg_ready = ~busy_q;
  assign slc_qen   = user_qen & ~busy_q;
  assign sdata     = sdata_q;
  assign sclk_en   = sclk_en_q;
  assign cfg_latch = cfg_latch_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
